// File: rtl/dst_hazard_tracker_pkg.sv
// Shared widths, forwarding-select encodings, the stage record and the
// register-match helpers used by the destination hazard tracker.
package dst_hazard_tracker_pkg;

    localparam int ADDR_W = 5;
    localparam int TNEW_W = 2;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    // D-stage forwarding sources
    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    // E-stage forwarding sources
    localparam logic [1:0] FWD_E_IDEX = 2'd0;
    localparam logic [1:0] FWD_E_M    = 2'd1;
    localparam logic [1:0] FWD_E_W    = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic              we;
        logic [TNEW_W-1:0] tnew;
    } stage_t;

    // A stage matches a source only if it writes that register and the register is not $0.
    function automatic logic stage_hit(input stage_t s, input logic [ADDR_W-1:0] src);
        return s.we && (s.dst == src) && (src != ZERO_REG);
    endfunction

    function automatic logic stage_ready(input stage_t s, input logic [ADDR_W-1:0] src);
        return stage_hit(s, src) && (s.tnew == '0);
    endfunction

    function automatic logic [1:0] fwd_d_sel(input stage_t e, input stage_t m, input stage_t w,
                                             input logic [ADDR_W-1:0] src);
        if (stage_ready(e, src))      return FWD_E;
        else if (stage_ready(m, src)) return FWD_M;
        else if (stage_ready(w, src)) return FWD_W;
        else                          return FWD_GRF;
    endfunction

    function automatic logic [1:0] fwd_e_sel(input stage_t m, input stage_t w,
                                             input logic [ADDR_W-1:0] src);
        if (stage_ready(m, src))      return FWD_E_M;
        else if (stage_ready(w, src)) return FWD_E_W;
        else                          return FWD_E_IDEX;
    endfunction

endpackage

// File: rtl/dst_hazard_tracker_stage_reg.sv
// One pipeline stage of {dst, we, tnew}: optional saturating Tnew decrement
// on load, bubble insertion and asynchronous clear.
module dst_stage_reg
    import dst_hazard_tracker_pkg::*;
#(
    parameter bit DECR = 1'b1
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   bubble_i,
    input  stage_t d_i,
    output stage_t q_o
);

    stage_t stage_q;
    stage_t stage_d;

    always_comb begin
        stage_d = d_i;
        if (DECR && (d_i.tnew != '0)) begin
            stage_d.tnew = d_i.tnew - TNEW_W'(1);
        end
        if (bubble_i) begin
            stage_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/dst_hazard_tracker.sv
// Tracks destination register, write-enable and Tnew through E/M/W and derives
// the D-stage stall, D/E forwarding selects and the GRF write port.
module dst_hazard_tracker
    import dst_hazard_tracker_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] d_dst_i,
    input  logic              d_we_i,
    input  logic [TNEW_W-1:0] d_tnew_i,
    input  logic [ADDR_W-1:0] d_rs_i,
    input  logic [ADDR_W-1:0] d_rt_i,
    input  logic              d_rs_use_i,
    input  logic              d_rt_use_i,
    input  logic [TNEW_W-1:0] d_tuse_rs_i,
    input  logic [TNEW_W-1:0] d_tuse_rt_i,
    output logic              stall_o,
    output logic [1:0]        fwd_d_rs_o,
    output logic [1:0]        fwd_d_rt_o,
    output logic [1:0]        fwd_e_rs_o,
    output logic [1:0]        fwd_e_rt_o,
    output logic [ADDR_W-1:0] w_dst_o,
    output logic              w_we_o
);

    stage_t e_in;
    stage_t e_q;
    stage_t m_q;
    stage_t w_q;

    logic [ADDR_W-1:0] rs_e_q, rs_e_d;
    logic [ADDR_W-1:0] rt_e_q, rt_e_d;
    logic              stall_rs;
    logic              stall_rt;

    // Writes to $0 are dropped here so nothing downstream ever sees them.
    assign e_in = '{dst: d_dst_i, we: d_we_i && (d_dst_i != ZERO_REG), tnew: d_tnew_i};

    dst_stage_reg #(.DECR(1'b0)) u_stage_e (
        .clk_i    (clk_i),
        .rst_i    (reset_i),
        .bubble_i (stall_o),
        .d_i      (e_in),
        .q_o      (e_q)
    );

    dst_stage_reg #(.DECR(1'b1)) u_stage_m (
        .clk_i    (clk_i),
        .rst_i    (reset_i),
        .bubble_i (1'b0),
        .d_i      (e_q),
        .q_o      (m_q)
    );

    dst_stage_reg #(.DECR(1'b1)) u_stage_w (
        .clk_i    (clk_i),
        .rst_i    (reset_i),
        .bubble_i (1'b0),
        .d_i      (m_q),
        .q_o      (w_q)
    );

    assign rs_e_d = stall_o ? ZERO_REG : d_rs_i;
    assign rt_e_d = stall_o ? ZERO_REG : d_rt_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rs_e_q <= '0;
            rt_e_q <= '0;
        end else begin
            rs_e_q <= rs_e_d;
            rt_e_q <= rt_e_d;
        end
    end

    // Only E and M can still be producing; W always has its result.
    always_comb begin
        stall_rs = d_rs_use_i &&
                   ((stage_hit(e_q, d_rs_i) && (e_q.tnew > d_tuse_rs_i)) ||
                    (stage_hit(m_q, d_rs_i) && (m_q.tnew > d_tuse_rs_i)));
        stall_rt = d_rt_use_i &&
                   ((stage_hit(e_q, d_rt_i) && (e_q.tnew > d_tuse_rt_i)) ||
                    (stage_hit(m_q, d_rt_i) && (m_q.tnew > d_tuse_rt_i)));
        stall_o  = stall_rs || stall_rt;
    end

    always_comb begin
        fwd_d_rs_o = fwd_d_sel(e_q, m_q, w_q, d_rs_i);
        fwd_d_rt_o = fwd_d_sel(e_q, m_q, w_q, d_rt_i);
        fwd_e_rs_o = fwd_e_sel(m_q, w_q, rs_e_q);
        fwd_e_rt_o = fwd_e_sel(m_q, w_q, rt_e_q);
    end

    assign w_dst_o = w_q.dst;
    assign w_we_o  = w_q.we;

endmodule

// File: tb/tb_dst_hazard_tracker.sv
// Bench for dst_hazard_tracker: directed hazard scenarios plus randomized
// instruction streams against an age-based pipeline model.
module tb_dst_hazard_tracker;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [4:0] d_dst_i, d_rs_i, d_rt_i;
    logic       d_we_i, d_rs_use_i, d_rt_use_i;
    logic [1:0] d_tnew_i, d_tuse_rs_i, d_tuse_rt_i;
    logic       stall_o, w_we_o;
    logic [1:0] fwd_d_rs_o, fwd_d_rt_o, fwd_e_rs_o, fwd_e_rt_o;
    logic [4:0] w_dst_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: slot 0=E, 1=M, 2=W; the stored Tnew is the value on entry to E,
    // and the slot index is how many cycles it has aged since then.
    logic [4:0] mdl_dst [3];
    bit         mdl_we  [3];
    int         mdl_t0  [3];
    logic [4:0] mdl_rs_e, mdl_rt_e;

    dst_hazard_tracker dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .d_dst_i     (d_dst_i),
        .d_we_i      (d_we_i),
        .d_tnew_i    (d_tnew_i),
        .d_rs_i      (d_rs_i),
        .d_rt_i      (d_rt_i),
        .d_rs_use_i  (d_rs_use_i),
        .d_rt_use_i  (d_rt_use_i),
        .d_tuse_rs_i (d_tuse_rs_i),
        .d_tuse_rt_i (d_tuse_rt_i),
        .stall_o     (stall_o),
        .fwd_d_rs_o  (fwd_d_rs_o),
        .fwd_d_rt_o  (fwd_d_rt_o),
        .fwd_e_rs_o  (fwd_e_rs_o),
        .fwd_e_rt_o  (fwd_e_rt_o),
        .w_dst_o     (w_dst_o),
        .w_we_o      (w_we_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int remaining(input int k);
        int r;
        r = mdl_t0[k] - k;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit writes(input int k, input logic [4:0] src);
        return mdl_we[k] && (mdl_dst[k] == src) && (src != 5'd0);
    endfunction

    function automatic bit src_blocked(input bit use_it, input logic [4:0] src, input int tuse);
        bit b = 1'b0;
        for (int k = 0; k < 2; k++)
            if (use_it && writes(k, src) && remaining(k) > tuse) b = 1'b1;
        return b;
    endfunction

    function automatic int exp_fwd_d(input logic [4:0] src);
        for (int k = 0; k < 3; k++)
            if (writes(k, src) && remaining(k) == 0) return k + 1;
        return 0;
    endfunction

    function automatic int exp_fwd_e(input logic [4:0] src);
        for (int k = 1; k < 3; k++)
            if (writes(k, src) && remaining(k) == 0) return k;
        return 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            mdl_dst[k] = 5'd0;
            mdl_we[k]  = 1'b0;
            mdl_t0[k]  = 0;
        end
        mdl_rs_e = 5'd0;
        mdl_rt_e = 5'd0;
    endtask

    task automatic drive(input int dst, input bit we, input int tnew,
                         input int rs, input bit rs_use, input int tuse_rs,
                         input int rt, input bit rt_use, input int tuse_rt);
        d_dst_i     = 5'(dst);
        d_we_i      = we;
        d_tnew_i    = 2'(tnew);
        d_rs_i      = 5'(rs);
        d_rs_use_i  = rs_use;
        d_tuse_rs_i = 2'(tuse_rs);
        d_rt_i      = 5'(rt);
        d_rt_use_i  = rt_use;
        d_tuse_rt_i = 2'(tuse_rt);
        #1;
    endtask

    // Check every output against the model, then advance one clock.
    task automatic cycle();
        bit exp_stall;
        exp_stall = src_blocked(d_rs_use_i, d_rs_i, int'(d_tuse_rs_i)) ||
                    src_blocked(d_rt_use_i, d_rt_i, int'(d_tuse_rt_i));
        check("stall",    32'(stall_o),    32'(exp_stall));
        check("fwd_d_rs", 32'(fwd_d_rs_o), 32'(exp_fwd_d(d_rs_i)));
        check("fwd_d_rt", 32'(fwd_d_rt_o), 32'(exp_fwd_d(d_rt_i)));
        check("fwd_e_rs", 32'(fwd_e_rs_o), 32'(exp_fwd_e(mdl_rs_e)));
        check("fwd_e_rt", 32'(fwd_e_rt_o), 32'(exp_fwd_e(mdl_rt_e)));
        check("w_we",     32'(w_we_o),     32'(mdl_we[2]));
        check("w_dst",    32'(w_dst_o),    32'(mdl_dst[2]));
        @(posedge clk_i);
        for (int k = 2; k > 0; k--) begin
            mdl_dst[k] = mdl_dst[k-1];
            mdl_we[k]  = mdl_we[k-1];
            mdl_t0[k]  = mdl_t0[k-1];
        end
        mdl_dst[0] = exp_stall ? 5'd0 : d_dst_i;
        mdl_we[0]  = exp_stall ? 1'b0 : (d_we_i && d_dst_i != 5'd0);
        mdl_t0[0]  = exp_stall ? 0 : int'(d_tnew_i);
        mdl_rs_e   = exp_stall ? 5'd0 : d_rs_i;
        mdl_rt_e   = exp_stall ? 5'd0 : d_rt_i;
        @(negedge clk_i);
    endtask

    task automatic flush();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle();
    endtask

    // Reset lands between edges; outputs must clear without waiting for a clock.
    task automatic pulse_reset(input string tag);
        reset_i = 1'b1;
        #1;
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_fwd"},   32'({fwd_d_rs_o, fwd_d_rt_o, fwd_e_rs_o, fwd_e_rt_o}), 32'd0);
        check({tag, "_w_we"},  32'(w_we_o), 32'd0);
        check({tag, "_w_dst"}, 32'(w_dst_o), 32'd0);
        model_clear();
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
    endtask

    initial begin
        int n_stall;
        model_clear();
        reset_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_w_we",  32'(w_we_o), 32'd0);
        reset_i = 1'b0;
        #1;

        // Reset mid-stream while E holds a pending write that is stalling D.
        flush();
        drive(7, 1, 3, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(11, 1, 1, 7, 1, 0, 0, 0, 0);
        check("t1_pre_stall", 32'(stall_o), 32'd1);
        pulse_reset("t1");

        // Load $8 (Tnew 2) followed by a reader needing rs immediately.
        flush();
        drive(8, 1, 2, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(10, 1, 1, 8, 1, 0, 0, 0, 0);
        n_stall = 0;
        for (int k = 0; k < 6; k++) begin
            if (!stall_o) break;
            n_stall++;
            cycle();
            #1;
        end
        check("t2_stalls",   32'(n_stall), 32'd2);
        check("t2_fwd_d_rs", 32'(fwd_d_rs_o), 32'd3);
        check("t2_w_we",     32'(w_we_o), 32'd1);
        check("t2_w_dst",    32'(w_dst_o), 32'd8);
        cycle();

        // ALU result (Tnew 1) consumed by a branch in D.
        flush();
        drive(9, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 9, 1, 0, 0, 0, 0);
        check("t3_stall", 32'(stall_o), 32'd1);
        cycle();
        #1;
        check("t3_released", 32'(stall_o), 32'd0);
        check("t3_fwd_d_rs", 32'(fwd_d_rs_o), 32'd2);
        cycle();

        // Store data needed late: no stall, forwarded into E from M.
        flush();
        drive(9, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 9, 1, 2);
        check("t4_stall", 32'(stall_o), 32'd0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t4_fwd_e_rt", 32'(fwd_e_rt_o), 32'd1);
        cycle();

        // Writes to $0 vanish.
        flush();
        drive(0, 1, 2, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 1, 0, 0, 1, 0);
        check("t5_stall", 32'(stall_o), 32'd0);
        check("t5_fwd",   32'(fwd_d_rs_o), 32'd0);
        cycle();
        cycle();
        check("t5_w_we", 32'(w_we_o), 32'd0);

        // $5 ready in both E and M: nearest wins.
        flush();
        drive(5, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        drive(0, 0, 0, 5, 1, 0, 0, 0, 0);
        check("t6_fwd_d_rs", 32'(fwd_d_rs_o), 32'd1);
        cycle();

        // Randomized streams over a small register set to force collisions.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset("rnd_rst");
            end else begin
                drive($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
